// File: rtl/easyobv_axis_gen_pkg.sv
// Shared types and constants for the AXI4-Stream traffic generator:
// FSM states, header field layout and the payload LFSR step.
package easyobv_axis_gen_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    PAY  = 3'd2,
    GAP  = 3'd3,
    FIN  = 3'd4
  } state_e;

  localparam int SEQ_LSB = 0;
  localparam int TS_LSB  = 32;

  localparam logic [31:0] LFSR_SEED = 32'hA5A5A5A5;

  // Right-shifting Galois LFSR: the bit shifted out selects the tap XOR.
  function automatic logic [31:0] lfsr32_next(input logic [31:0] value,
                                              input logic [31:0] poly);
    logic [31:0] shifted;
    shifted = {1'b0, value[31:1]};
    return value[0] ? (shifted ^ poly) : shifted;
  endfunction

endpackage

// File: rtl/easyobv_axis_gen.sv
// AXI4-Stream packet generator: header beat (sequence number + launch
// timestamp) followed by LFSR payload, with inter-packet gaps and abort.
module easyobv_axis_gen
  import easyobv_axis_gen_pkg::*;
#(
  parameter int          DWIDTH    = 64,
  parameter logic [31:0] LFSR_POLY = 32'h80200003
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [15:0]         cfg_pkt_len,
  input  logic [31:0]         cfg_num_pkts,
  input  logic [15:0]         cfg_gap,
  input  logic [63:0]         time_cnt,
  output logic [DWIDTH-1:0]   m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [DWIDTH/8-1:0] m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic                busy,
  output logic                done,
  output logic [63:0]         pkt_sent
);

  localparam int LANES = DWIDTH / 32;

  state_e              state_q, state_d;
  logic [15:0]         len_m1_q, len_m1_d;
  logic [31:0]         num_q, num_d;
  logic [15:0]         gap_q, gap_d;
  logic [31:0]         seq_q, seq_d;
  logic [63:0]         pkt_sent_q, pkt_sent_d;
  logic [15:0]         beat_q, beat_d;
  logic [15:0]         gap_cnt_q, gap_cnt_d;
  logic [31:0]         lfsr_q, lfsr_d;
  logic                abort_q, abort_d;
  logic [DWIDTH-1:0]   tdata_q, tdata_d;
  logic                tvalid_q, tvalid_d;
  logic                tlast_q, tlast_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ts_live_q, ts_live_d;

  logic                hs;
  logic                last_pkt;
  logic                load_hdr;
  logic [31:0]         hdr_seq;
  logic                unused_time_hi;

  function automatic logic [DWIDTH-1:0] hdr_word(input logic [31:0] seq);
    logic [DWIDTH-1:0] w;
    w = '0;
    w[SEQ_LSB +: 32] = seq;
    return w;
  endfunction

  function automatic logic [DWIDTH-1:0] lane_rep(input logic [31:0] v);
    return {LANES{v}};
  endfunction

  assign hs             = tvalid_q & m_axis_tready;
  assign last_pkt       = (num_q != 32'd0) && ((pkt_sent_q + 64'd1) == {32'd0, num_q});
  assign unused_time_hi = ^time_cnt[63:32];

  always_comb begin
    state_d    = state_q;
    len_m1_d   = len_m1_q;
    num_d      = num_q;
    gap_d      = gap_q;
    seq_d      = seq_q;
    pkt_sent_d = pkt_sent_q;
    beat_d     = beat_q;
    gap_cnt_d  = gap_cnt_q;
    lfsr_d     = lfsr_q;
    abort_d    = abort_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ts_live_d  = 1'b0;
    load_hdr   = 1'b0;
    hdr_seq    = seq_q;

    unique case (state_q)
      IDLE: begin
        // abort arriving with start is deliberately not recorded
        if (start) begin
          len_m1_d   = (cfg_pkt_len == 16'd0) ? 16'd0 : cfg_pkt_len - 16'd1;
          num_d      = cfg_num_pkts;
          gap_d      = cfg_gap;
          seq_d      = 32'd0;
          pkt_sent_d = 64'd0;
          abort_d    = 1'b0;
          busy_d     = 1'b1;
          load_hdr   = 1'b1;
          hdr_seq    = 32'd0;
        end
      end

      HDR, PAY: begin
        abort_d = abort_q | abort;
        // The timestamp shown live in the first header cycle is frozen here.
        if (ts_live_q) tdata_d[TS_LSB +: 32] = time_cnt[31:0];
        if (hs) begin
          if (tlast_q) begin
            pkt_sent_d = (&pkt_sent_q) ? pkt_sent_q : pkt_sent_q + 64'd1;
            seq_d      = seq_q + 32'd1;
            if (abort_q || abort || last_pkt) begin
              state_d  = FIN;
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
              done_d   = 1'b1;
            end else if (gap_q != 16'd0) begin
              state_d   = GAP;
              gap_cnt_d = gap_q;
              tvalid_d  = 1'b0;
              tlast_d   = 1'b0;
            end else begin
              load_hdr = 1'b1;
              hdr_seq  = seq_d;
            end
          end else begin
            lfsr_d  = lfsr32_next((state_q == HDR) ? (seq_q ^ LFSR_SEED) : lfsr_q, LFSR_POLY);
            beat_d  = beat_q + 16'd1;
            tdata_d = lane_rep(lfsr_d);
            tlast_d = (beat_d == len_m1_q);
            state_d = PAY;
          end
        end
      end

      GAP: begin
        abort_d = abort_q | abort;
        if (abort_q || abort) begin
          state_d = FIN;
          done_d  = 1'b1;
        end else if (gap_cnt_q <= 16'd1) begin
          load_hdr = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - 16'd1;
        end
      end

      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        abort_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        abort_d = 1'b0;
      end
    endcase

    if (load_hdr) begin
      state_d   = HDR;
      tvalid_d  = 1'b1;
      tdata_d   = hdr_word(hdr_seq);
      tlast_d   = (len_m1_d == 16'd0);
      ts_live_d = 1'b1;
      beat_d    = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_m1_q   <= '0;
      num_q      <= '0;
      gap_q      <= '0;
      seq_q      <= '0;
      pkt_sent_q <= '0;
      beat_q     <= '0;
      gap_cnt_q  <= '0;
      lfsr_q     <= '0;
      abort_q    <= 1'b0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ts_live_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_m1_q   <= len_m1_d;
      num_q      <= num_d;
      gap_q      <= gap_d;
      seq_q      <= seq_d;
      pkt_sent_q <= pkt_sent_d;
      beat_q     <= beat_d;
      gap_cnt_q  <= gap_cnt_d;
      lfsr_q     <= lfsr_d;
      abort_q    <= abort_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ts_live_q  <= ts_live_d;
    end
  end

  always_comb begin
    m_axis_tdata = tdata_q;
    if (ts_live_q) m_axis_tdata[TS_LSB +: 32] = time_cnt[31:0];
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tkeep  = tvalid_q ? {(DWIDTH/8){1'b1}} : {(DWIDTH/8){1'b0}};
  assign busy          = busy_q;
  assign done          = done_q;
  assign pkt_sent      = pkt_sent_q;

endmodule
